simon_job_controller: RTL and testbench
=======================================

// Module: simon_job_controller
// PURPOSE
//  Sequences the Simon32/64 encrypt and decrypt cores for frames delivered by the UART receive path.
//  Buffers one pending frame and selects the core by the mode bit.
//  Launches the core, waits for its result with a timeout, and hands the 32-bit result to the UART sender.
//  Sits between get_data, the two cipher cores and send_data, and replaces ad-hoc edge-sync/mux glue.
// PARAMETERS
//  TIMEOUT_CYCLES  1023  max cycles in WAIT before the job is abandoned (>=2)
//  CNT_W           10    timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//  clk          in   1    system clock
//  rst          in   1    asynchronous reset, active-high
//  frame_valid  in   1    1-cycle pulse: frame_data holds a new frame
//  frame_data   in   104  [31:0] block, [95:32] key, [96] mode (0=enc, 1=dec), [103:97] ignored
//  enc_start    out  1    1-cycle load/start pulse to encrypt core
//  dec_start    out  1    1-cycle load/start pulse to decrypt core
//  core_key     out  64   key to both cores; stable from LAUNCH through WAIT
//  core_block   out  32   block to both cores; stable from LAUNCH through WAIT
//  enc_rdy      in   1    encrypt core done level; drops on load
//  enc_result   in   32   encrypt core output
//  dec_rdy      in   1    decrypt core done level; drops on load
//  dec_result   in   32   decrypt core output
//  tx_valid     out  1    result available for send_data
//  tx_data      out  32   result word; stable while tx_valid=1
//  tx_ready     in   1    send_data idle; transfer occurs when tx_valid & tx_ready
//  busy         out  1    1 when state != IDLE or the pending slot is full
//  drop_cnt     out  8    frames dropped because the pending slot was full; saturates at 255
//  timeout_err  out  1    sticky; set on any timeout, cleared only by rst
// BEHAVIOUR
//  Reset:
//   - All outputs 0, state IDLE, pending slot empty, counters 0.
//   - Reset applies immediately mid-operation: the job is aborted and no tx occurs.
//  Pending slot (1 entry):
//   - On frame_valid with the slot empty, or with the slot being consumed this same cycle, the frame is captured.
//   - Otherwise the frame is discarded and drop_cnt increments (saturating).
//  FSM:
//   - IDLE:   if the slot is full, move the slot into the job register (key, block, mode), free the slot, go to LAUNCH.
//   - LAUNCH: assert enc_start (mode=0) or dec_start (mode=1) for exactly one cycle. Clear the timer. Go to WAIT.
//   - WAIT:   sel_rdy = mode ? dec_rdy : enc_rdy; rdy_q is sel_rdy delayed one cycle.
//     - Done when sel_rdy & ~rdy_q. On done, capture the selected result into tx_data and go to SEND.
//     - Otherwise the timer increments. When the timer reaches TIMEOUT_CYCLES-1 without done, set timeout_err and go to IDLE with no tx.
//     - Done and timeout in the same cycle: done wins.
//   - SEND:   tx_valid=1 and held until tx_ready=1. On transfer, tx_valid drops next cycle and the FSM goes to IDLE.
//  Latency:
//   - Idle block, frame_valid at cycle 0: slot full at cycle 1, LAUNCH at cycle 2, start pulse visible in cycle 2.
//   - Done detected in cycle N: tx_valid=1 in cycle N+1.
//  Masking and ordering:
//   - The non-selected core's rdy/result are ignored.
//   - enc_start and dec_start are never both 1.
//   - Frames are processed strictly in arrival order. At most 2 frames are in flight (job + pending).
//  Timer width: CNT_W bits, no wrap possible (compare stops it).
// TESTING
//  - Enc path: mode=0, key=0x1918111009080100, block=0x65656877.
//    -> enc_start pulse 2 cycles after frame_valid; after enc_rdy rises, tx_data=0xc69be9bb, one tx transfer.
//  - Dec path: mode=1, block=0xc69be9bb, same key.
//    -> dec_start only, tx_data=0x65656877. Toggling enc_rdy during the job has no effect.
//  - Back-to-back: 3 frame_valid pulses 5 cycles apart while job 1 is in WAIT.
//    -> frame 2 pending, frame 3 dropped, drop_cnt=1; frame 2 launches after frame 1 transfer.
//  - Backpressure: hold tx_ready=0 for 50 cycles in SEND -> tx_valid and tx_data stable; exactly 1 transfer when released.
//  - Timeout: TIMEOUT_CYCLES=16, rdy never rises.
//    -> timeout_err=1 after 16 WAIT cycles, no tx_valid, FSM IDLE; the next frame still completes normally.
//  - Reset mid-WAIT -> all outputs 0 in the same cycle; drop_cnt=0; a later rdy edge produces no tx.

Source files
------------

// File: rtl/simon_job_controller.sv
// Job sequencer between the UART frame receiver, the Simon32/64 encrypt/decrypt cores and the UART sender.
// One pending frame is buffered while a job runs; results wait in SEND until the sender accepts them.
module simon_job_controller #(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int CNT_W          = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         frame_valid,
    input  logic [103:0] frame_data,
    output logic         enc_start,
    output logic         dec_start,
    output logic [63:0]  core_key,
    output logic [31:0]  core_block,
    input  logic         enc_rdy,
    input  logic [31:0]  enc_result,
    input  logic         dec_rdy,
    input  logic [31:0]  dec_result,
    output logic         tx_valid,
    output logic [31:0]  tx_data,
    input  logic         tx_ready,
    output logic         busy,
    output logic [7:0]   drop_cnt,
    output logic         timeout_err,
    output logic [1:0]   dbg_state
);

    // tx handshake: tx_valid rises only in SEND and holds tx_data steady until a
    // cycle with tx_valid & tx_ready; that cycle is the single transfer.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_SEND   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic             slot_full_q, slot_full_d;
    logic [63:0]      slot_key_q;
    logic [31:0]      slot_block_q;
    logic             slot_mode_q;
    logic [63:0]      job_key_q;
    logic [31:0]      job_block_q;
    logic             job_mode_q;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             rdy_q;
    logic [31:0]      tx_data_q, tx_data_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic             timeout_err_q, timeout_err_d;

    logic             job_load;
    logic             slot_take;
    logic             sel_rdy;
    logic [31:0]      sel_result;
    logic             done;
    logic             unused_bits;

    assign unused_bits = ^frame_data[103:97];

    // Only the core chosen by the job's mode is observed.
    assign sel_rdy    = job_mode_q ? dec_rdy : enc_rdy;
    assign sel_result = job_mode_q ? dec_result : enc_result;
    assign done       = sel_rdy & ~rdy_q;

    // A frame may land in the slot in the same cycle IDLE moves the old one out.
    assign slot_take   = frame_valid & (~slot_full_q | job_load);
    assign slot_full_d = slot_take | (slot_full_q & ~job_load);
    assign drop_cnt_d  = (frame_valid && !slot_take && drop_cnt_q != 8'hff) ? drop_cnt_q + 8'd1 : drop_cnt_q;

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        tx_data_d     = tx_data_q;
        timeout_err_d = timeout_err_q;
        job_load      = 1'b0;
        enc_start     = 1'b0;
        dec_start     = 1'b0;
        tx_valid      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (slot_full_q) begin
                    job_load = 1'b1;
                    state_d  = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                enc_start = ~job_mode_q;
                dec_start = job_mode_q;
                timer_d   = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // A completion in the final timer cycle still counts.
                if (done) begin
                    tx_data_d = sel_result;
                    state_d   = S_SEND;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            S_SEND: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            slot_full_q   <= 1'b0;
            slot_key_q    <= '0;
            slot_block_q  <= '0;
            slot_mode_q   <= 1'b0;
            job_key_q     <= '0;
            job_block_q   <= '0;
            job_mode_q    <= 1'b0;
            timer_q       <= '0;
            rdy_q         <= 1'b0;
            tx_data_q     <= '0;
            drop_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_full_q   <= slot_full_d;
            timer_q       <= timer_d;
            rdy_q         <= sel_rdy;
            tx_data_q     <= tx_data_d;
            drop_cnt_q    <= drop_cnt_d;
            timeout_err_q <= timeout_err_d;
            if (slot_take) begin
                slot_key_q   <= frame_data[95:32];
                slot_block_q <= frame_data[31:0];
                slot_mode_q  <= frame_data[96];
            end
            if (job_load) begin
                job_key_q   <= slot_key_q;
                job_block_q <= slot_block_q;
                job_mode_q  <= slot_mode_q;
            end
        end
    end

    assign core_key    = job_key_q;
    assign core_block  = job_block_q;
    assign tx_data     = tx_data_q;
    assign drop_cnt    = drop_cnt_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q != S_IDLE) | slot_full_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_simon_job_controller.sv
// Bench for simon_job_controller: stand-in cipher cores, a transaction-level model of
// frames/results/drops/timeouts, and directed scenarios with literal expectations.
module tb_simon_job_controller;

    localparam logic [63:0] KEY = 64'h1918111009080100;

    logic         clk = 1'b0;
    logic         rst;
    logic         frame_valid;
    logic [103:0] frame_data;
    logic         enc_start, dec_start;
    logic [63:0]  core_key;
    logic [31:0]  core_block;
    logic         enc_rdy, dec_rdy;
    logic [31:0]  enc_result, dec_result;
    logic         tx_valid;
    logic [31:0]  tx_data;
    logic         tx_ready;
    logic         busy;
    logic [7:0]   drop_cnt;
    logic         timeout_err;
    logic [1:0]   dbg_state;

    always #5 clk = ~clk;

    simon_job_controller #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_data(frame_data),
        .enc_start(enc_start), .dec_start(dec_start), .core_key(core_key), .core_block(core_block),
        .enc_rdy(enc_rdy), .enc_result(enc_result), .dec_rdy(dec_rdy), .dec_result(dec_result),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .busy(busy),
        .drop_cnt(drop_cnt), .timeout_err(timeout_err), .dbg_state(dbg_state)
    );

    typedef struct {
        logic        mode;
        logic [63:0] key;
        logic [31:0] block;
        bit          hang;
    } job_t;

    job_t        frame_q[$];
    logic [31:0] exp_q[$];
    int          exp_drop = 0;
    logic        exp_to = 1'b0;
    int          xfers = 0;
    logic [31:0] last_tx = '0;
    int          total = 0;
    int          passed = 0;

    int core_lat = 6;
    bit core_hang = 1'b0;
    bit enc_toggle = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Stand-in cores: known-answer vectors for the reference key, a fixed scramble otherwise.
    function automatic logic [31:0] core_fn(input logic dec, input logic [63:0] k, input logic [31:0] b);
        if (k == KEY && !dec && b == 32'h65656877) return 32'hc69be9bb;
        if (k == KEY && dec && b == 32'hc69be9bb) return 32'h65656877;
        if (dec) return ~b ^ k[63:32];
        return {b[15:0], b[31:16]} ^ k[31:0];
    endfunction

    initial begin
        int ecnt = 0;
        int dcnt = 0;
        logic e_ld, d_ld;
        logic [63:0] ek, dk;
        logic [31:0] eb, db;
        enc_rdy = 1'b0; dec_rdy = 1'b0; enc_result = '0; dec_result = '0;
        ek = '0; dk = '0; eb = '0; db = '0;
        forever begin
            @(negedge clk);
            e_ld = enc_start;
            d_ld = dec_start;
            if (e_ld) begin ek = core_key; eb = core_block; end
            if (d_ld) begin dk = core_key; db = core_block; end
            @(posedge clk);
            #1;
            if (e_ld) begin
                enc_rdy = 1'b0; ecnt = core_lat;
            end else if (ecnt > 0) begin
                ecnt--;
                if (ecnt == 0 && !core_hang) begin enc_rdy = 1'b1; enc_result = core_fn(1'b0, ek, eb); end
            end else if (enc_toggle) begin
                enc_rdy = ~enc_rdy; enc_result = $urandom;
            end
            if (d_ld) begin
                dec_rdy = 1'b0; dcnt = core_lat;
            end else if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0 && !core_hang) begin dec_rdy = 1'b1; dec_result = core_fn(1'b1, dk, db); end
            end
        end
    end

    // Compare process: every cycle out of reset, outputs against the model.
    initial begin
        job_t        cur;
        bit          in_job = 1'b0;
        int          cd = 0;
        bit          prev_hold = 1'b0;
        logic [31:0] prev_tx = '0;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_job = 1'b0; cd = 0; prev_hold = 1'b0;
                continue;
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin exp_to = 1'b1; in_job = 1'b0; end
            end
            chk("start_exclusive", 64'(enc_start & dec_start), 64'd0);
            if (enc_start || dec_start) begin
                if (frame_q.size() == 0) chk("unexpected_start", 64'd1, 64'd0);
                else begin
                    cur = frame_q.pop_front();
                    chk("start_sel", 64'({dec_start, enc_start}), cur.mode ? 64'd2 : 64'd1);
                    chk("launch_key", core_key, cur.key);
                    chk("launch_block", 64'(core_block), 64'(cur.block));
                    chk("launch_after_tx", 64'(exp_q.size()), 64'd0);
                    in_job = 1'b1;
                    // Abandon after 16 WAIT cycles; the flag shows the cycle after that.
                    if (cur.hang) cd = 17;
                    else exp_q.push_back(core_fn(cur.mode, cur.key, cur.block));
                end
            end else if (in_job) begin
                chk("key_stable", core_key, cur.key);
                chk("block_stable", 64'(core_block), 64'(cur.block));
            end
            if (tx_valid) begin
                in_job = 1'b0;
                if (prev_hold) chk("tx_data_stable", 64'(tx_data), 64'(prev_tx));
                if (exp_q.size() == 0) chk("tx_valid_unexpected", 64'd1, 64'd0);
                else if (tx_ready) begin
                    e = exp_q.pop_front();
                    chk("tx_data", 64'(tx_data), 64'(e));
                    xfers++;
                    last_tx = tx_data;
                end
                prev_hold = !tx_ready;
                prev_tx = tx_data;
            end else begin
                if (prev_hold) chk("tx_valid_held", 64'd0, 64'd1);
                prev_hold = 1'b0;
            end
            chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
            chk("timeout_err", 64'(timeout_err), 64'(exp_to));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic mode, input logic [63:0] key, input logic [31:0] block,
                              input bit accept, input bit hang);
        job_t j;
        frame_data = {7'($urandom), mode, key, block};
        frame_valid = 1'b1;
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
        frame_data = {8'($urandom), $urandom, $urandom, $urandom};
        if (accept) begin
            j.mode = mode; j.key = key; j.block = block; j.hang = hang;
            frame_q.push_back(j);
        end else if (exp_drop < 255) exp_drop++;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((frame_q.size() != 0 || exp_q.size() != 0 || busy) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) chk(name, 64'd1, 64'd0);
        idle(2);
    endtask

    task automatic wait_tx(input string name);
        int n = 0;
        while (!tx_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) chk(name, 64'd1, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; frame_valid = 1'b0; frame_data = '0; tx_ready = 1'b1;
        idle(2);
        chk("rst_enc_start", 64'(enc_start), 64'd0);
        chk("rst_dec_start", 64'(dec_start), 64'd0);
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_core_key", core_key, 64'd0);
        chk("rst_tx_data", 64'(tx_data), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        rst = 1'b0;
        idle(2);

        // Encrypt path: start pulse in cycle 2, done in cycle 9, tx_valid in cycle 10.
        send_frame(1'b0, KEY, 32'h65656877, 1'b1, 1'b0);
        @(negedge clk);
        chk("enc_cycle1_start", 64'(enc_start), 64'd0);
        chk("enc_cycle1_busy", 64'(busy), 64'd1);
        @(negedge clk);
        chk("enc_cycle2_start", 64'({dec_start, enc_start}), 64'd1);
        repeat (7) @(negedge clk);
        chk("enc_cycle9_tx_valid", 64'(tx_valid), 64'd0);
        @(negedge clk);
        chk("enc_cycle10_tx_valid", 64'(tx_valid), 64'd1);
        chk("enc_result", 64'(tx_data), 64'hc69be9bb);
        @(posedge clk);
        #1;
        wait_drain("enc_drain");
        chk("enc_xfers", 64'(xfers), 64'd1);

        // Decrypt path while the encrypt core's rdy toggles.
        enc_toggle = 1'b1;
        send_frame(1'b1, KEY, 32'hc69be9bb, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("dec_cycle2_start", 64'({dec_start, enc_start}), 64'd2);
        @(posedge clk);
        #1;
        wait_drain("dec_drain");
        enc_toggle = 1'b0;
        chk("dec_xfers", 64'(xfers), 64'd2);
        chk("dec_result", 64'(last_tx), 64'h65656877);

        // Back-to-back: job 1 waits 14 cycles; frame 2 parks, frame 3 is dropped.
        core_lat = 14;
        send_frame(1'b0, KEY, 32'h12345678, 1'b1, 1'b0);
        idle(4);
        send_frame(1'b1, KEY, 32'h9abcdef0, 1'b1, 1'b0);
        idle(4);
        send_frame(1'b0, KEY, 32'h0badf00d, 1'b0, 1'b0);
        @(negedge clk);
        chk("b2b_drop_cnt", 64'(drop_cnt), 64'd1);
        chk("b2b_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        wait_drain("b2b_drain");
        chk("b2b_xfers", 64'(xfers), 64'd4);

        // Backpressure: result held for 50 cycles, exactly one transfer on release.
        core_lat = 6;
        tx_ready = 1'b0;
        send_frame(1'b0, 64'($urandom) << 32 | 64'($urandom), $urandom, 1'b1, 1'b0);
        wait_tx("bp_tx_wait");
        idle(50);
        chk("bp_tx_valid_held", 64'(tx_valid), 64'd1);
        chk("bp_xfers_before", 64'(xfers), 64'd4);
        tx_ready = 1'b1;
        wait_drain("bp_drain");
        chk("bp_xfers", 64'(xfers), 64'd5);

        // Timeout: WAIT spans cycles 3..18, flag visible in cycle 19.
        core_hang = 1'b1;
        send_frame(1'b0, KEY, 32'h55aa55aa, 1'b1, 1'b1);
        repeat (18) @(negedge clk);
        chk("to_cycle18_err", 64'(timeout_err), 64'd0);
        @(negedge clk);
        chk("to_cycle19_err", 64'(timeout_err), 64'd1);
        chk("to_cycle19_busy", 64'(busy), 64'd0);
        chk("to_cycle19_tx_valid", 64'(tx_valid), 64'd0);
        @(posedge clk);
        #1;
        core_hang = 1'b0;
        idle(3);
        send_frame(1'b1, KEY, $urandom, 1'b1, 1'b0);
        wait_drain("to_next_drain");
        chk("to_next_xfers", 64'(xfers), 64'd6);

        // Reset in the middle of WAIT.
        send_frame(1'b0, KEY, 32'h01020304, 1'b1, 1'b0);
        idle(3);
        #2;
        rst = 1'b1;
        frame_q.delete();
        exp_q.delete();
        exp_drop = 0;
        exp_to = 1'b0;
        #1;
        chk("mid_rst_outputs", 64'({enc_start, dec_start, tx_valid, busy, timeout_err}), 64'd0);
        chk("mid_rst_core_key", core_key, 64'd0);
        chk("mid_rst_core_block", 64'(core_block), 64'd0);
        chk("mid_rst_tx_data", 64'(tx_data), 64'd0);
        chk("mid_rst_drop_cnt", 64'(drop_cnt), 64'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(15);
        chk("post_rst_no_tx", 64'(xfers), 64'd6);
        send_frame(1'b0, KEY, 32'h65656877, 1'b1, 1'b0);
        wait_drain("post_rst_drain");
        chk("post_rst_xfers", 64'(xfers), 64'd7);
        chk("post_rst_result", 64'(last_tx), 64'hc69be9bb);

        chk("final_frame_q_empty", 64'(frame_q.size()), 64'd0);
        chk("final_exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
